// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - widths, opcodes, FSM states and decoded-control struct
package control_unit_pkg;

  localparam int PC_BITS  = 11;
  localparam int E_BITS   = 16;
  localparam int D_BITS   = 11;
  localparam int OP_BITS  = 5;
  localparam int S_BITS   = 2;
  localparam int CNT_BITS = 16;

  localparam logic [OP_BITS-1:0] OP_HLT  = 5'b00000;
  localparam logic [OP_BITS-1:0] OP_STO  = 5'b00001;
  localparam logic [OP_BITS-1:0] OP_LD   = 5'b00010;
  localparam logic [OP_BITS-1:0] OP_LDI  = 5'b00011;
  localparam logic [OP_BITS-1:0] OP_ADD  = 5'b00100;
  localparam logic [OP_BITS-1:0] OP_ADDI = 5'b00101;
  localparam logic [OP_BITS-1:0] OP_SUB  = 5'b00110;
  localparam logic [OP_BITS-1:0] OP_SUBI = 5'b00111;

  localparam logic [S_BITS-1:0] SEL_A_RAM = 2'b00;
  localparam logic [S_BITS-1:0] SEL_A_IMM = 2'b01;
  localparam logic [S_BITS-1:0] SEL_A_ALU = 2'b10;
  localparam logic SEL_B_RAM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;
  localparam logic ALU_ADD   = 1'b0;
  localparam logic ALU_SUB   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_OPER,
    ST_EXEC,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic [S_BITS-1:0] sel_a;
    logic              sel_b;
    logic              op;
    logic              w_acc;
    logic              wr_ram;
    logic              rd_ram;
  } ctrl_t;

  function automatic logic [OP_BITS-1:0] opcode_of(input logic [E_BITS-1:0] instr);
    return instr[E_BITS-1 -: OP_BITS];
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - program-memory and datapath-control bundle of the control unit
interface control_unit_if;
  import control_unit_pkg::*;

  logic                i_start;
  logic [E_BITS-1:0]   i_Instr;
  logic [PC_BITS-1:0]  o_Addr_prog;
  logic                o_rd_prog;
  logic [D_BITS-1:0]   o_Data;
  logic [S_BITS-1:0]   o_sel_A;
  logic                o_sel_B;
  logic                o_op;
  logic                o_w_acc;
  logic                o_rd_ram;
  logic                o_wr_ram;
  logic                o_halted;
  logic [CNT_BITS-1:0] o_instr_count;

  modport master (
    input  i_start, i_Instr,
    output o_Addr_prog, o_rd_prog, o_Data, o_sel_A, o_sel_B, o_op,
           o_w_acc, o_rd_ram, o_wr_ram, o_halted, o_instr_count
  );

  modport slave (
    output i_start, i_Instr,
    input  o_Addr_prog, o_rd_prog, o_Data, o_sel_A, o_sel_B, o_op,
           o_w_acc, o_rd_ram, o_wr_ram, o_halted, o_instr_count
  );

endinterface

// File: rtl/control_unit_decoder.sv
// rtl/control_unit_decoder.sv - combinational opcode to datapath-control decode
module control_unit_decoder
  import control_unit_pkg::*;
(
  input  logic [OP_BITS-1:0] opcode_i,
  output ctrl_t              ctrl_o
);

  // HLT and the unassigned opcodes decode to all-zero controls (NOP)
  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_STO: ctrl_o.wr_ram = 1'b1;
      OP_LD: begin
        ctrl_o.sel_a  = SEL_A_RAM;
        ctrl_o.w_acc  = 1'b1;
        ctrl_o.rd_ram = 1'b1;
      end
      OP_LDI: begin
        ctrl_o.sel_a = SEL_A_IMM;
        ctrl_o.w_acc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        ctrl_o.sel_a  = SEL_A_ALU;
        ctrl_o.sel_b  = SEL_B_RAM;
        ctrl_o.op     = (opcode_i == OP_SUB) ? ALU_SUB : ALU_ADD;
        ctrl_o.w_acc  = 1'b1;
        ctrl_o.rd_ram = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        ctrl_o.sel_a = SEL_A_ALU;
        ctrl_o.sel_b = SEL_B_IMM;
        ctrl_o.op    = (opcode_i == OP_SUBI) ? ALU_SUB : ALU_ADD;
        ctrl_o.w_acc = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - 4-cycle fetch/decode controller: PC, IR, retired counter, strobe gating
module control_unit
  import control_unit_pkg::*;
(
  input  logic           i_clock,
  input  logic           i_reset,
  control_unit_if.master cu_io
);

  state_e              state_q;
  logic [PC_BITS-1:0]  pc_q;
  logic [E_BITS-1:0]   ir_q;
  logic [S_BITS-1:0]   sel_a_q;
  logic                sel_b_q;
  logic                op_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                rd_prog_q;
  logic                rd_ram_q;
  logic                w_acc_q;
  logic                wr_ram_q;
  logic                halted_q;
  logic [OP_BITS-1:0]  dec_opcode;
  ctrl_t               ctrl;

  // One decoder serves both uses: the incoming word in LOAD (for the RAM read
  // issued in OPER) and the latched IR in OPER (for the EXEC controls).
  assign dec_opcode = (state_q == ST_LOAD) ? opcode_of(cu_io.i_Instr) : opcode_of(ir_q);

  control_unit_decoder u_decoder (
    .opcode_i (dec_opcode),
    .ctrl_o   (ctrl)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      sel_a_q   <= '0;
      sel_b_q   <= 1'b0;
      op_q      <= 1'b0;
      cnt_q     <= '0;
      rd_prog_q <= 1'b0;
      rd_ram_q  <= 1'b0;
      w_acc_q   <= 1'b0;
      wr_ram_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      rd_prog_q <= 1'b0;
      rd_ram_q  <= 1'b0;
      w_acc_q   <= 1'b0;
      wr_ram_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cu_io.i_start) begin
            state_q   <= ST_FETCH;
            rd_prog_q <= 1'b1;
          end
        end
        ST_FETCH: state_q <= ST_LOAD;
        ST_LOAD: begin
          ir_q     <= cu_io.i_Instr;
          rd_ram_q <= ctrl.rd_ram;
          state_q  <= ST_OPER;
        end
        ST_OPER: begin
          sel_a_q  <= ctrl.sel_a;
          sel_b_q  <= ctrl.sel_b;
          op_q     <= ctrl.op;
          w_acc_q  <= ctrl.w_acc;
          wr_ram_q <= ctrl.wr_ram;
          state_q  <= ST_EXEC;
        end
        ST_EXEC: begin
          if (opcode_of(ir_q) == OP_HLT) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            pc_q      <= pc_q + PC_BITS'(1);
            cnt_q     <= (cnt_q == '1) ? cnt_q : cnt_q + CNT_BITS'(1);
            rd_prog_q <= 1'b1;
            state_q   <= ST_FETCH;
          end
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes are masked by reset in the same cycle so an aborted instruction never writes
  assign cu_io.o_rd_prog     = rd_prog_q & ~i_reset;
  assign cu_io.o_rd_ram      = rd_ram_q & ~i_reset;
  assign cu_io.o_w_acc       = w_acc_q & ~i_reset;
  assign cu_io.o_wr_ram      = wr_ram_q & ~i_reset;
  assign cu_io.o_Addr_prog   = pc_q;
  assign cu_io.o_Data        = ir_q[D_BITS-1:0];
  assign cu_io.o_sel_A       = sel_a_q;
  assign cu_io.o_sel_B       = sel_b_q;
  assign cu_io.o_op          = op_q;
  assign cu_io.o_halted      = halted_q;
  assign cu_io.o_instr_count = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] mem [2048];
  logic        pend = 1'b0;
  logic [10:0] pend_addr = '0;

  control_unit_if cu_if ();

  control_unit dut (
    .i_clock (clk),
    .i_reset (rst),
    .cu_io   (cu_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          len;
    logic [15:0] prog [8];
    bit          rand_start;
    logic [10:0] pc;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input int cyc, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // Advance one cycle; program memory answers one cycle after o_rd_prog, garbage otherwise
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cu_if.i_Instr = pend ? mem[pend_addr] : 16'($urandom);
    pend      = cu_if.o_rd_prog;
    pend_addr = cu_if.o_Addr_prog;
  endtask

  function automatic logic [63:0] all_outs();
    return {cu_if.o_rd_prog, cu_if.o_rd_ram, cu_if.o_w_acc, cu_if.o_wr_ram, cu_if.o_halted,
            cu_if.o_Addr_prog, cu_if.o_instr_count, cu_if.o_Data, cu_if.o_sel_A,
            cu_if.o_sel_B, cu_if.o_op};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cu_if.i_start = 1'b0;
    tick();
    tick();
    rst  = 1'b0;
    pend = 1'b0;
  endtask

  // Instruction-level reference: each instruction is 4 cycles, effects derived from the opcode table
  task automatic run_model(input string nm, input int max_cyc, input bit rand_start);
    int pc = 0;
    int cnt = 0;
    int ph = 0;
    int post = 0;
    bit halted = 0;
    logic [15:0] ir = '0;
    logic [4:0]  opc;
    logic e_rdp, e_rdr, e_wacc, e_wr;
    logic [1:0] e_sela;
    cu_if.i_start = 1'b1;
    tick();
    for (int c = 0; c < max_cyc && post < 4; c++) begin
      if (!halted && ph == 0) ir = mem[pc];
      opc    = ir[15:11];
      e_rdp  = !halted && ph == 0;
      e_rdr  = !halted && ph == 2 && (opc == 5'd2 || opc == 5'd4 || opc == 5'd6);
      e_wacc = !halted && ph == 3 && opc >= 5'd2 && opc <= 5'd7;
      e_wr   = !halted && ph == 3 && opc == 5'd1;
      chk({nm, ".ctl"}, c,
          {cu_if.o_rd_prog, cu_if.o_rd_ram, cu_if.o_w_acc, cu_if.o_wr_ram, cu_if.o_halted,
           cu_if.o_Addr_prog, cu_if.o_instr_count},
          {e_rdp, e_rdr, e_wacc, e_wr, halted, 11'(pc), 16'(cnt)});
      if (!halted && ph >= 2) chk({nm, ".data"}, c, 64'(cu_if.o_Data), 64'(ir[10:0]));
      if (e_wacc) begin
        e_sela = (opc == 5'd2) ? 2'b00 : (opc == 5'd3) ? 2'b01 : 2'b10;
        if (opc >= 5'd4)
          chk({nm, ".alu"}, c, {cu_if.o_sel_A, cu_if.o_sel_B, cu_if.o_op}, {e_sela, opc[0], opc[1]});
        else
          chk({nm, ".selA"}, c, 64'(cu_if.o_sel_A), 64'(e_sela));
      end
      if (!halted && ph == 3) begin
        if (opc == 5'd0) halted = 1;
        else begin
          pc = (pc + 1) % 2048;
          if (cnt < 65535) cnt++;
        end
      end
      ph = (ph + 1) % 4;
      if (halted) post++;
      cu_if.i_start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    cu_if.i_start = 1'b0;
  endtask

  task automatic load_prog(input logic [15:0] fill);
    for (int a = 0; a < 2048; a++) mem[a] = fill;
  endtask

  initial begin
    cu_if.i_start = 1'b0;
    cu_if.i_Instr = '0;
    vecs[0] = '{"prog_basic", 4, '{16'h1805, 16'h2803, 16'h0810, 16'h0000, 0, 0, 0, 0}, 1'b0, 11'd3, 16'd3};
    vecs[1] = '{"ld_sub", 3, '{16'h1004, 16'h3004, 16'h0000, 0, 0, 0, 0, 0}, 1'b1, 11'd2, 16'd2};
    vecs[2] = '{"nop_1f", 2, '{16'hF8AB, 16'h0000, 0, 0, 0, 0, 0, 0}, 1'b0, 11'd1, 16'd1};
    vecs[3] = '{"mixed", 5, '{16'h2007, 16'h3801, 16'h17FF, 16'h4000, 16'h0000, 0, 0, 0}, 1'b1, 11'd4, 16'd4};
    vecs[4] = '{"hlt_first", 1, '{16'h0123, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 11'd0, 16'd0};
    vecs[5] = '{"neg_imm", 3, '{16'h1FFF, 16'h2C00, 16'h0000, 0, 0, 0, 0, 0}, 1'b0, 11'd2, 16'd2};

    do_reset();
    chk("reset_all", 0, all_outs(), 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle", i, all_outs(), 64'd0);
    end

    for (int v = 0; v < 6; v++) begin
      load_prog(16'h0000);
      for (int k = 0; k < vecs[v].len; k++) mem[k] = vecs[v].prog[k];
      do_reset();
      run_model(vecs[v].name, 4 * vecs[v].len + 12, vecs[v].rand_start);
      chk({vecs[v].name, ".final"}, 0,
          {cu_if.o_halted, cu_if.o_Addr_prog, cu_if.o_instr_count},
          {1'b1, vecs[v].pc, vecs[v].cnt});
    end

    for (int r = 0; r < 15; r++) begin
      load_prog(16'h0000);
      for (int k = 0; k < 10; k++) mem[k] = {5'($urandom_range(1, 31)), 11'($urandom)};
      if (r % 3 == 0) mem[$urandom_range(0, 9)] = 16'(11'($urandom));
      do_reset();
      run_model($sformatf("rand%0d", r), 4 * 11 + 12, 1'b1);
      chk($sformatf("rand%0d.halt", r), 0, 64'(cu_if.o_halted), 64'd1);
    end

    load_prog(16'h4000);
    do_reset();
    run_model("wrap", 2048 * 4 + 1, 1'b0);
    chk("wrap.addr", 0, 64'(cu_if.o_Addr_prog), 64'd0);
    chk("wrap.cnt", 0, 64'(cu_if.o_instr_count), 64'd2048);
    chk("wrap.halted", 0, 64'(cu_if.o_halted), 64'd0);

    load_prog(16'h0000);
    mem[0] = 16'h0810;
    do_reset();
    cu_if.i_start = 1'b1;
    tick();
    cu_if.i_start = 1'b0;
    tick();
    tick();
    chk("rst_exec.oper_data", 0, 64'(cu_if.o_Data), 64'h010);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_exec.strobes", 0, {cu_if.o_wr_ram, cu_if.o_w_acc, cu_if.o_rd_prog, cu_if.o_rd_ram}, 64'd0);
    tick();
    chk("rst_exec.after", 0, all_outs(), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_exec.idle", i, all_outs(), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
